control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired Moore control unit that drives the System datapath control inputs.
- Replaces bench-driven control: it runs the instruction fetch, decodes the IR opcode, and steps through the execute T-states of the supported instructions.
- Supported instructions: ldi, jr, jal, R-format ALU ops, nop, halt.
- Connects directly to the System control port list. It reads the IR value and nothing else from the datapath.

Parameters:
- DATA_WIDTH, 32, IR width.
- OP_ADD, 5'b00011, ALU opcode issued for ldi address/immediate add.

Ports:
- Clock  input  1  system clock; all state changes on rising edge.
- clear  input  1  synchronous active-high reset.
- run  input  1  1 = sequencer may leave IDLE/HALT; 0 = hold in IDLE after reset.
- IR  input  DATA_WIDTH  instruction register contents; IR[31:27] = instruction opcode.
- PCout, MDRout, Zlo_out, Zhi_out, HIout, LOout, Inport_out, Cout  output  1 each  bus drive selects.
- MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin  output  1 each  register load enables.
- Gra, Grb, Grc, Rin, Rout, BAout  output  1 each  register-file select/enable.
- IncPC  output  1  ALU increments PC.
- opcode  output  5  ALU operation select.
- Mem_Read, Mem_Write, Mem_enable512x32  output  1 each  memory controls.
- halted  output  1  high while in HALT.

Behaviour:
- Moore machine; all outputs are a pure decode of the registered state.
- opcode is also a function of state and the latched IR.
- States: IDLE, T0, T1, T2, DEC, LDI3, LDI4, LDI5, JR3, JAL3, JAL4, R3, R4, R5, HALT.
- DEC is a zero-output decode cycle, so decode uses an IR that was stably loaded at the end of T2.
- Reset (clear=1 at a rising edge): state <= IDLE regardless of current state, including mid-instruction. All outputs are 0 in IDLE, opcode=0, halted=0.
- IDLE: go to T0 when run=1, else stay.

Fetch:
- T0: PCout, IncPC, MARin, Zin.
- T1: Zlo_out, PCin, MDRin, Mem_Read, Mem_enable512x32. The memory result is captured into MDR at the end of T1.
- T2: MDRout, IRin.
- Fetch latency is 3 cycles; T0->T1->T2->DEC unconditionally.

Decode (DEC), on IR[31:27]:
- 00001 -> LDI3
- 10100 -> JR3
- 10101 -> JAL3
- 00011..01000 -> R3
- 11011 -> HALT
- 11010 (nop) and any other code -> T0 (undefined opcodes behave as nop).

Execute states:
- ldi:
  - LDI3: Grb, BAout, Yin.
  - LDI4: Cout, Zin, opcode=OP_ADD.
  - LDI5: Zlo_out, Gra, Rin.
  - Then -> T0.
- jr: JR3: Gra, Rout, PCin. Then -> T0.
- jal:
  - JAL3: PCout, Grb, Rin. Links the already-incremented PC into R[rb].
  - JAL4: Gra, Rout, PCin.
  - Then -> T0.
  - If ra==rb, the final PC is the link value; no special handling is required.
- R-format:
  - R3: Grb, Rout, Yin.
  - R4: Grc, Rout, Zin, opcode=IR[31:27].
  - R5: Zlo_out, Gra, Rin.
  - Then -> T0.
- HALT: halted=1, all other outputs 0. Leave only via clear.

Cycles per instruction (fetch + DEC + execute):
- ldi 7
- jr 5
- jal 6
- R-format 7
- nop 4

Signal rules:
- No state ever asserts more than one bus driver. Bus drivers are PCout, MDRout, Zlo_out, Zhi_out, HIout, LOout, Inport_out, Cout, Rout, BAout.
- Mem_Write, HIin, LOin, Zhi_out, HIout, LOout, Inport_out are 0 in every state. They are reserved for later load/store, mul/div and I/O extensions.
- run is sampled only in IDLE; deasserting run mid-program has no effect.

Test Plan:
- Reset and IDLE: clear=1 for 2 cycles in state JAL4, then clear=0, run=0 for 5 cycles -> state IDLE every cycle, all outputs 0, halted=0. Then run=1 -> T0 next edge with PCout=IncPC=MARin=Zin=1.
- ldi: IR=32'h0B000003 (ldi r6,3) presented after T2 -> DEC, LDI3 (Grb,BAout,Yin), LDI4 (Cout,Zin,opcode=00011), LDI5 (Zlo_out,Gra,Rin), then T0. 7 cycles T0-to-T0.
- jr: IR=32'hA3000000 (jr r6) -> JR3 asserts exactly Gra,Rout,PCin, then T0. 5 cycles T0-to-T0.
- jal: IR=32'hAB780000 (jal r6, link r15) -> JAL3 asserts PCout,Grb,Rin; JAL4 asserts Gra,Rout,PCin; then T0.
- R-format and undefined: IR[31:27]=00100 -> R4 opcode=00100 with Grc,Rout,Zin. IR[31:27]=11110 -> DEC then T0 with no execute signals.
- halt: IR[31:27]=11011 -> HALT; halted=1 held for 10 cycles with all other outputs 0; clear=1 -> IDLE, halted=0.
- Global check in all scenarios: at most one bus driver asserted in any cycle; Mem_Write never asserted.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the System datapath.
// Runs fetch, decodes IR[31:27] and steps the execute T-states.
module control_sequencer #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [4:0]  OP_ADD     = 5'b00011
) (
  input  logic                  Clock,
  input  logic                  clear,
  input  logic                  run,
  input  logic [DATA_WIDTH-1:0] IR,
  output logic                  PCout,
  output logic                  MDRout,
  output logic                  Zlo_out,
  output logic                  Zhi_out,
  output logic                  HIout,
  output logic                  LOout,
  output logic                  Inport_out,
  output logic                  Cout,
  output logic                  MARin,
  output logic                  Zin,
  output logic                  PCin,
  output logic                  MDRin,
  output logic                  IRin,
  output logic                  Yin,
  output logic                  HIin,
  output logic                  LOin,
  output logic                  Gra,
  output logic                  Grb,
  output logic                  Grc,
  output logic                  Rin,
  output logic                  Rout,
  output logic                  BAout,
  output logic                  IncPC,
  output logic [4:0]            opcode,
  output logic                  Mem_Read,
  output logic                  Mem_Write,
  output logic                  Mem_enable512x32,
  output logic                  halted
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_DEC,
    S_LDI3,
    S_LDI4,
    S_LDI5,
    S_JR3,
    S_JAL3,
    S_JAL4,
    S_R3,
    S_R4,
    S_R5,
    S_HALT
  } state_t;

  localparam logic [4:0] OPC_LDI  = 5'b00001;
  localparam logic [4:0] OPC_JR   = 5'b10100;
  localparam logic [4:0] OPC_JAL  = 5'b10101;
  localparam logic [4:0] OPC_RLO  = 5'b00011;
  localparam logic [4:0] OPC_RHI  = 5'b01000;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  state_t     state;
  state_t     state_nx;
  logic [4:0] ir_op;
  logic [4:0] op_q;
  logic       unused_ir;

  assign ir_op     = IR[DATA_WIDTH-1 -: 5];
  assign unused_ir = ^IR[DATA_WIDTH-6:0];

  // State register; clear wins over any in-flight instruction.
  always_ff @(posedge Clock) begin
    if (clear) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Latch the opcode at decode so R4 sees the decoded instruction.
  always_ff @(posedge Clock) begin
    if (clear)              op_q <= 5'b0;
    else if (state == S_DEC) op_q <= ir_op;
  end

  // Next-state: fixed fetch, opcode decode, then execute steps.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: state_nx = run ? S_T0 : S_IDLE;
      S_T0:   state_nx = S_T1;
      S_T1:   state_nx = S_T2;
      S_T2:   state_nx = S_DEC;
      S_DEC: begin
        unique case (1'b1)
          (ir_op == OPC_LDI):  state_nx = S_LDI3;
          (ir_op == OPC_JR):   state_nx = S_JR3;
          (ir_op == OPC_JAL):  state_nx = S_JAL3;
          (ir_op >= OPC_RLO &&
           ir_op <= OPC_RHI):  state_nx = S_R3;
          (ir_op == OPC_HALT): state_nx = S_HALT;
          default:             state_nx = S_T0;
        endcase
      end
      S_LDI3: state_nx = S_LDI4;
      S_LDI4: state_nx = S_LDI5;
      S_LDI5: state_nx = S_T0;
      S_JR3:  state_nx = S_T0;
      S_JAL3: state_nx = S_JAL4;
      S_JAL4: state_nx = S_T0;
      S_R3:   state_nx = S_R4;
      S_R4:   state_nx = S_R5;
      S_R5:   state_nx = S_T0;
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output decode of the registered state only.
  always_comb begin
    PCout            = 1'b0;
    MDRout           = 1'b0;
    Zlo_out          = 1'b0;
    Zhi_out          = 1'b0;
    HIout            = 1'b0;
    LOout            = 1'b0;
    Inport_out       = 1'b0;
    Cout             = 1'b0;
    MARin            = 1'b0;
    Zin              = 1'b0;
    PCin             = 1'b0;
    MDRin            = 1'b0;
    IRin             = 1'b0;
    Yin              = 1'b0;
    HIin             = 1'b0;
    LOin             = 1'b0;
    Gra              = 1'b0;
    Grb              = 1'b0;
    Grc              = 1'b0;
    Rin              = 1'b0;
    Rout             = 1'b0;
    BAout            = 1'b0;
    IncPC            = 1'b0;
    opcode           = 5'b0;
    Mem_Read         = 1'b0;
    Mem_Write        = 1'b0;
    Mem_enable512x32 = 1'b0;
    halted           = 1'b0;
    unique case (state)
      S_T0: begin
        PCout = 1'b1;
        IncPC = 1'b1;
        MARin = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlo_out          = 1'b1;
        PCin             = 1'b1;
        MDRin            = 1'b1;
        Mem_Read         = 1'b1;
        Mem_enable512x32 = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_LDI3: begin
        Grb   = 1'b1;
        BAout = 1'b1;
        Yin   = 1'b1;
      end
      S_LDI4: begin
        Cout   = 1'b1;
        Zin    = 1'b1;
        opcode = OP_ADD;
      end
      S_LDI5, S_R5: begin
        Zlo_out = 1'b1;
        Gra     = 1'b1;
        Rin     = 1'b1;
      end
      S_JR3, S_JAL4: begin
        Gra  = 1'b1;
        Rout = 1'b1;
        PCin = 1'b1;
      end
      S_JAL3: begin
        PCout = 1'b1;
        Grb   = 1'b1;
        Rin   = 1'b1;
      end
      S_R3: begin
        Grb  = 1'b1;
        Rout = 1'b1;
        Yin  = 1'b1;
      end
      S_R4: begin
        Grc    = 1'b1;
        Rout   = 1'b1;
        Zin    = 1'b1;
        opcode = op_q;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer.
// Table vectors, hand sequences and a random program vs. a reference model.
module tb_control_sequencer;

  logic        Clock;
  logic        clear;
  logic        run;
  logic [31:0] IR;
  logic PCout, MDRout, Zlo_out, Zhi_out, HIout, LOout, Inport_out, Cout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin;
  logic Gra, Grb, Grc, Rin, Rout, BAout, IncPC;
  logic [4:0] opcode;
  logic Mem_Read, Mem_Write, Mem_enable512x32, halted;

  control_sequencer #(.DATA_WIDTH(32), .OP_ADD(5'b00011)) dut (
    .Clock(Clock), .clear(clear), .run(run), .IR(IR),
    .PCout(PCout), .MDRout(MDRout), .Zlo_out(Zlo_out),
    .Zhi_out(Zhi_out), .HIout(HIout), .LOout(LOout),
    .Inport_out(Inport_out), .Cout(Cout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .IncPC(IncPC), .opcode(opcode),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .Mem_enable512x32(Mem_enable512x32), .halted(halted)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // bit positions of the observed control word; bits 0..9 are bus drivers
  localparam int B_PCO = 0,  B_MDRO = 1, B_ZLO = 2,  B_ZHI = 3;
  localparam int B_HIO = 4,  B_LOO = 5,  B_INP = 6,  B_CO = 7;
  localparam int B_RO = 8,   B_BA = 9,   B_MAR = 10, B_ZIN = 11;
  localparam int B_PCI = 12, B_MDRI = 13, B_IRI = 14, B_YIN = 15;
  localparam int B_HII = 16, B_LOI = 17, B_GRA = 18, B_GRB = 19;
  localparam int B_GRC = 20, B_RIN = 21, B_INC = 22, B_MRD = 23;
  localparam int B_MWR = 24, B_MEN = 25, B_HLT = 26;

  logic [31:0] obs;
  assign obs = {5'b0, halted, Mem_enable512x32, Mem_Write, Mem_Read,
                IncPC, Rin, Grc, Grb, Gra, LOin, HIin, Yin, IRin,
                MDRin, PCin, Zin, MARin, BAout, Rout, Cout, Inport_out,
                LOout, HIout, Zhi_out, Zlo_out, MDRout, PCout};

  function automatic logic [31:0] bm(input int b);
    return 32'd1 << b;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  // expected {opcode, mask} per cycle of one instruction, starting at T0
  logic [36:0] exp_q[$];

  task automatic push(input logic [31:0] m, input logic [4:0] op);
    exp_q.push_back({op, m});
  endtask

  // Reference: fetch + decode cycle, then execute steps by instruction class.
  task automatic build(input logic [31:0] ir);
    logic [4:0] op;
    op = ir[31:27];
    exp_q.delete();
    push(bm(B_PCO) | bm(B_INC) | bm(B_MAR) | bm(B_ZIN), 5'd0);
    push(bm(B_ZLO) | bm(B_PCI) | bm(B_MDRI) | bm(B_MRD) | bm(B_MEN), 5'd0);
    push(bm(B_MDRO) | bm(B_IRI), 5'd0);
    push(32'd0, 5'd0);
    if (op == 5'd1) begin
      push(bm(B_GRB) | bm(B_BA) | bm(B_YIN), 5'd0);
      push(bm(B_CO) | bm(B_ZIN), 5'd3);
      push(bm(B_ZLO) | bm(B_GRA) | bm(B_RIN), 5'd0);
    end else if (op == 5'd20) begin
      push(bm(B_GRA) | bm(B_RO) | bm(B_PCI), 5'd0);
    end else if (op == 5'd21) begin
      push(bm(B_PCO) | bm(B_GRB) | bm(B_RIN), 5'd0);
      push(bm(B_GRA) | bm(B_RO) | bm(B_PCI), 5'd0);
    end else if (op >= 5'd3 && op <= 5'd8) begin
      push(bm(B_GRB) | bm(B_RO) | bm(B_YIN), 5'd0);
      push(bm(B_GRC) | bm(B_RO) | bm(B_ZIN), op);
      push(bm(B_ZLO) | bm(B_GRA) | bm(B_RIN), 5'd0);
    end else if (op == 5'd27) begin
      push(bm(B_HLT), 5'd0);
    end
  endtask

  // advance one cycle and apply the global rules to the new state
  task automatic step();
    @(posedge Clock);
    #1;
    n_cmp++;
    if ($countones(obs[9:0]) > 1 || Mem_Write !== 1'b0) begin
      n_bad++;
      $display("FAIL bus_rule t=%0t got obs=%h required <=1 driver, no Mem_Write",
               $time, obs);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] m,
                     input logic [4:0] op);
    n_cmp++;
    if (obs !== m || opcode !== op) begin
      n_bad++;
      $display("FAIL %s t=%0t got mask=%h op=%b required mask=%h op=%b",
               nm, $time, obs, opcode, m, op);
    end
  endtask

  // DUT sits in T0; check the whole instruction, end in the next T0
  task automatic run_instr(input logic [31:0] ir, input string nm);
    IR = ir;
    build(ir);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k > 0) step();
      chk($sformatf("%s_c%0d", nm, k), exp_q[k][31:0], exp_q[k][36:32]);
    end
    if (ir[31:27] != 5'd27) step();
  endtask

  typedef struct {
    logic [31:0] ir;
    int          cycles;
    logic        halt;
    logic [4:0]  xop;
  } vec_t;

  vec_t tbl[12];

  localparam logic [31:0] W_T0 = (32'd1 << 0) | (32'd1 << 22) |
                                 (32'd1 << 10) | (32'd1 << 11);

  initial begin
    int n;
    logic [4:0] xop;
    logic [4:0] op;

    tbl[0]  = '{32'h0B000003, 7, 1'b0, 5'b00011};
    tbl[1]  = '{32'hA3000000, 5, 1'b0, 5'b00000};
    tbl[2]  = '{32'hAB780000, 6, 1'b0, 5'b00000};
    tbl[3]  = '{32'h18884000, 7, 1'b0, 5'b00011};
    tbl[4]  = '{32'h20884000, 7, 1'b0, 5'b00100};
    tbl[5]  = '{32'h40884000, 7, 1'b0, 5'b01000};
    tbl[6]  = '{32'hD0000000, 4, 1'b0, 5'b00000};
    tbl[7]  = '{32'hF0000000, 4, 1'b0, 5'b00000};
    tbl[8]  = '{32'h00000000, 4, 1'b0, 5'b00000};
    tbl[9]  = '{32'h48000000, 4, 1'b0, 5'b00000};
    tbl[10] = '{32'h10000000, 4, 1'b0, 5'b00000};
    tbl[11] = '{32'hD8000000, 4, 1'b1, 5'b00000};

    clear = 1'b1;
    run   = 1'b0;
    IR    = 32'h0;
    step();
    step();
    chk("reset_idle", 32'd0, 5'd0);

    // reset arriving mid-jal, then idle with run low
    clear = 1'b0;
    run   = 1'b1;
    step();
    chk("idle_to_t0", W_T0, 5'd0);
    IR = 32'hAB780000;
    build(IR);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("jal_pre_c%0d", k), exp_q[k][31:0], exp_q[k][36:32]);
    end
    clear = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("clear_in_jal4", 32'd0, 5'd0);
    end
    clear = 1'b0;
    run   = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("idle_hold", 32'd0, 5'd0);
    end
    run = 1'b1;
    step();
    chk("run_t0", W_T0, 5'd0);

    // table: cycles T0->T0 (or ->HALT) and ALU opcode seen
    foreach (tbl[i]) begin
      IR  = tbl[i].ir;
      n   = 0;
      xop = 5'd0;
      do begin
        step();
        n++;
        if (opcode != 5'd0) xop = opcode;
      end while (!IncPC && !halted && n < 20);
      n_cmp++;
      if (n != tbl[i].cycles || halted !== tbl[i].halt ||
          xop !== tbl[i].xop) begin
        n_bad++;
        $display("FAIL tbl%0d got cyc=%0d halt=%b op=%b required cyc=%0d halt=%b op=%b",
                 i, n, halted, xop, tbl[i].cycles, tbl[i].halt, tbl[i].xop);
      end
    end

    // halt holds regardless of run, leaves only via clear
    for (int k = 0; k < 10; k++) begin
      run = k[0];
      step();
      chk("halt_hold", bm(B_HLT), 5'd0);
    end
    run   = 1'b1;
    clear = 1'b1;
    step();
    chk("halt_clear", 32'd0, 5'd0);
    clear = 1'b0;
    step();
    chk("restart_t0", W_T0, 5'd0);

    // random program; run toggles mid-program without effect
    for (int i = 0; i < 60; i++) begin
      op = 5'($urandom_range(0, 31));
      if (i % 3 == 0) op = 5'($urandom_range(0, 8));
      if (op == 5'd27) op = 5'd26;
      run = 1'($urandom);
      run_instr({op, 27'($urandom)}, $sformatf("rnd%0d", i));
    end
    run_instr({5'd27, 27'($urandom)}, "rnd_halt");
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rnd_halt_hold", bm(B_HLT), 5'd0);
    end
    clear = 1'b1;
    step();
    chk("final_clear", 32'd0, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
